puf_host_seq: RTL and testbench

//  Parametrised on-chip host sequencer for the PUF core. Replaces bench-driven stimulus:

---
 rtl/puf_soc_pkg.sv | 30 +++
 rtl/puf_sync_fifo.sv | 94 +++++++++
 rtl/puf_host_seq.sv | 211 +++++++++++++++++++++
 tb/tb_puf_host_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_soc_pkg.sv
// Shared types and helpers for the PUF host sequencer.
//   host_seq_state_t : sequencer FSM states
//   host_err_t       : error code reported on o_err_code
//   cnt_width()      : bits needed to hold the values 0..max_val
package puf_soc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SEND     = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } host_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ABORT   = 2'd2
  } host_err_t;

  // Never returns 0, so it is always safe as a vector width.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/puf_sync_fifo.sv
// Single-clock FIFO with synchronous flush.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         empties the FIFO; a push in the same cycle is dropped
//   push_i/wdata_i  write request and data, ignored while full
//   pop_i           read request, ignored while empty
//   rdata_o         head word (valid while !empty_o)
//   full_o/empty_o  decoded from the registered word count only
module puf_sync_fifo
  import puf_soc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 32'd1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and count; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {AW{1'b0}} : wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {AW{1'b0}} : rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1'b1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1'b1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents behind an empty count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/puf_host_seq.sv
// On-chip host sequencer for the PUF core.
// Buffers challenge words, starts the core, streams one FRAM_SIZE-word frame over the
// core rx port, collects RSP_LEN response words from its tx port, and reports
// done / timeout / abort plus a count of good frames.
// Ports:
//   h_chal_*   host challenge push (ready = challenge FIFO not full)
//   h_cmd_*    start-frame request, accepted only in IDLE; h_abort cancels a frame
//   h_rsp_*    host response pop (valid = response FIFO not empty)
//   o_done/o_err/o_err_code/o_frame_cnt   status
//   o_puf_* / i_puf_*                     PUF core start/mode, rx and tx streams
module puf_host_seq
  import puf_soc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAM_SIZE   = 16,
  parameter int unsigned RSP_LEN     = 4,
  parameter int unsigned CHAL_DEPTH  = 32,
  parameter int unsigned RSP_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_chal_valid,
  output logic              h_chal_ready,
  input  logic [DATA_W-1:0] h_chal_data,
  input  logic              h_cmd_valid,
  output logic              h_cmd_ready,
  input  logic              h_cmd_mode,
  input  logic              h_abort,
  output logic              h_rsp_valid,
  input  logic              h_rsp_ready,
  output logic [DATA_W-1:0] h_rsp_data,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic              o_puf_start,
  output logic              o_puf_op_mode,
  output logic              o_puf_rx_valid,
  input  logic              i_puf_rx_ready,
  output logic [DATA_W-1:0] o_puf_rx_data,
  input  logic              i_puf_tx_valid,
  output logic              o_puf_tx_ready,
  input  logic [DATA_W-1:0] i_puf_tx_data
);

  localparam int unsigned WC_W = cnt_width(FRAM_SIZE);
  localparam int unsigned RC_W = cnt_width(RSP_LEN);
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYC);
  localparam bit          TO_EN = (TIMEOUT_CYC != 32'd0);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAM_SIZE - 32'd1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RSP_LEN - 32'd1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);

  host_seq_state_t   state_q, state_d;
  logic              mode_q, mode_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [RC_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              err_q, err_d;
  host_err_t         err_code_q, err_code_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic              chal_full, chal_empty;
  logic              rsp_full, rsp_empty;
  logic [DATA_W-1:0] chal_head;
  logic              rx_hs, tx_hs, abort_hit;

  // Challenge buffer; an abort flushes it (a host word pushed in that cycle is lost too).
  puf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(CHAL_DEPTH)) u_chal_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort_hit),
    .push_i  (h_chal_valid),
    .wdata_i (h_chal_data),
    .pop_i   (rx_hs),
    .rdata_o (chal_head),
    .full_o  (chal_full),
    .empty_o (chal_empty)
  );

  // Response buffer; never flushed so partial responses survive an abort.
  puf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (tx_hs),
    .wdata_i (i_puf_tx_data),
    .pop_i   (h_rsp_ready),
    .rdata_o (h_rsp_data),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  assign h_chal_ready   = ~chal_full;
  assign h_cmd_ready    = (state_q == IDLE);
  assign h_rsp_valid    = ~rsp_empty;
  assign o_puf_start    = (state_q == START);
  assign o_puf_op_mode  = (state_q != IDLE) & mode_q;
  assign o_puf_rx_valid = (state_q == SEND) & ~chal_empty;
  assign o_puf_rx_data  = chal_head;
  assign o_puf_tx_ready = (state_q == WAIT_RSP) & ~rsp_full;
  assign o_done         = (state_q == DONE);
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;
  assign o_frame_cnt    = frame_cnt_q;

  assign rx_hs     = o_puf_rx_valid & i_puf_rx_ready;
  assign tx_hs     = i_puf_tx_valid & o_puf_tx_ready;
  assign abort_hit = h_abort & (state_q inside {START, SEND, WAIT_RSP});

  // Next-state logic; abort is applied last so it overrides timeout and completion.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    word_cnt_d  = word_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    idle_cnt_d  = {TO_W{1'b0}};
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (h_cmd_valid) begin
          mode_d     = h_cmd_mode;
          err_code_d = ERR_NONE;
          word_cnt_d = {WC_W{1'b0}};
          rsp_cnt_d  = {RC_W{1'b0}};
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = SEND;
      end
      SEND: begin
        if (rx_hs) begin
          if (word_cnt_q == WC_LAST) begin
            state_d = WAIT_RSP;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1'b1);
          end
        end else begin
          state_d = SEND;
        end
      end
      WAIT_RSP: begin
        if (tx_hs) begin
          if (rsp_cnt_q == RC_LAST) begin
            // Count on entry to DONE so o_frame_cnt is already updated during o_done.
            state_d     = DONE;
            frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
          end else begin
            rsp_cnt_d = rsp_cnt_q + RC_W'(1'b1);
          end
        end else if (TO_EN) begin
          idle_cnt_d = idle_cnt_q + TO_W'(1'b1);
          if (idle_cnt_q == TO_LAST) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            state_d = WAIT_RSP;
          end
        end else begin
          state_d = WAIT_RSP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d     = IDLE;
      err_d       = 1'b1;
      err_code_d  = ERR_ABORT;
      frame_cnt_d = frame_cnt_q;
    end else begin
      err_d = err_d;
    end
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      word_cnt_q  <= {WC_W{1'b0}};
      rsp_cnt_q   <= {RC_W{1'b0}};
      idle_cnt_q  <= {TO_W{1'b0}};
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      word_cnt_q  <= word_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_puf_host_seq.sv
// Directed bench for puf_host_seq: a table of complete frames plus hand-written
// sequences for stalls, abort, response back-pressure, timeout and mid-frame reset.
module tb_puf_host_seq;

  localparam int DATA_W      = 8;
  localparam int FRAM_SIZE   = 16;
  localparam int RSP_LEN     = 4;
  localparam int CHAL_DEPTH  = 32;
  localparam int RSP_DEPTH   = 2;
  localparam int TIMEOUT_CYC = 1024;
  localparam int CNT_W       = 2;

  logic              clk, rst_n;
  logic              h_chal_valid, h_chal_ready;
  logic [DATA_W-1:0] h_chal_data;
  logic              h_cmd_valid, h_cmd_ready, h_cmd_mode, h_abort;
  logic              h_rsp_valid, h_rsp_ready;
  logic [DATA_W-1:0] h_rsp_data;
  logic              o_done, o_err;
  logic [1:0]        o_err_code;
  logic [CNT_W-1:0]  o_frame_cnt;
  logic              o_puf_start, o_puf_op_mode, o_puf_rx_valid, i_puf_rx_ready;
  logic [DATA_W-1:0] o_puf_rx_data;
  logic              i_puf_tx_valid, o_puf_tx_ready;
  logic [DATA_W-1:0] i_puf_tx_data;

  puf_host_seq #(
    .DATA_W(DATA_W), .FRAM_SIZE(FRAM_SIZE), .RSP_LEN(RSP_LEN), .CHAL_DEPTH(CHAL_DEPTH),
    .RSP_DEPTH(RSP_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_chal_valid(h_chal_valid), .h_chal_ready(h_chal_ready), .h_chal_data(h_chal_data),
    .h_cmd_valid(h_cmd_valid), .h_cmd_ready(h_cmd_ready), .h_cmd_mode(h_cmd_mode),
    .h_abort(h_abort),
    .h_rsp_valid(h_rsp_valid), .h_rsp_ready(h_rsp_ready), .h_rsp_data(h_rsp_data),
    .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt),
    .o_puf_start(o_puf_start), .o_puf_op_mode(o_puf_op_mode),
    .o_puf_rx_valid(o_puf_rx_valid), .i_puf_rx_ready(i_puf_rx_ready),
    .o_puf_rx_data(o_puf_rx_data),
    .i_puf_tx_valid(i_puf_tx_valid), .o_puf_tx_ready(o_puf_tx_ready),
    .i_puf_tx_data(i_puf_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] push_base;
    int         n_push;
    logic [7:0] exp_rx_base;
    logic [7:0] tx_base;
    logic [1:0] exp_cnt;
  } frame_vec_t;

  frame_vec_t tbl [5];

  int n_cmp = 0;
  int n_fail = 0;

  // Core model / monitor state (updated at negedge+1)
  logic       core_rx_ready = 1'b1;
  logic       core_tx_en    = 1'b1;
  logic       drain_en      = 1'b1;
  int         rx_limit      = 1000;
  logic [7:0] tx_base       = 8'h00;
  int         tx_left = 0, tx_idx = 0, tx_cnt = 0;
  int         start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         rx_valid_cycles = 0;
  int         lat = 0, done_lat = 0, to_cnt = 0, err_to = 0;
  logic       start_mode = 1'b0;
  logic [1:0] done_frame_cnt = 2'd0;
  logic [7:0] rx_q[$];
  logic [7:0] rsp_got[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // PUF core model plus host response drain; drives at negedge, observes at negedge+1.
  initial begin
    i_puf_rx_ready = 1'b0;
    i_puf_tx_valid = 1'b0;
    i_puf_tx_data  = 8'h00;
    h_rsp_ready    = 1'b0;
    forever begin
      @(negedge clk);
      i_puf_rx_ready = core_rx_ready && (rx_q.size() < rx_limit);
      i_puf_tx_valid = core_tx_en && (tx_left > 0);
      i_puf_tx_data  = tx_base + 8'(tx_idx);
      h_rsp_ready    = drain_en;
      #1;
      if (o_puf_rx_valid) rx_valid_cycles++;
      if (o_puf_rx_valid && i_puf_rx_ready) rx_q.push_back(o_puf_rx_data);
      if (i_puf_tx_valid && o_puf_tx_ready) begin
        tx_left--; tx_idx++; tx_cnt++;
      end
      if (o_puf_start) begin
        start_cnt++; start_mode = o_puf_op_mode; tx_left = RSP_LEN; tx_idx = 0;
      end
      if (h_rsp_valid && h_rsp_ready) rsp_got.push_back(h_rsp_data);
      if (h_cmd_valid && h_cmd_ready) begin
        lat = 0; to_cnt = 0;
      end else begin
        lat++;
        if (o_puf_tx_ready) to_cnt++;
      end
      if (o_done) begin
        done_cnt++; done_frame_cnt = o_frame_cnt; done_lat = lat;
      end
      if (o_err) begin
        err_cnt++; err_to = to_cnt;
      end
    end
  end

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_chal_valid = 1'b1;
      h_chal_data  = base + 8'(i);
      #2;
      chk("chal_ready", h_chal_ready, 1);
    end
    @(negedge clk);
    h_chal_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic mode);
    @(negedge clk);
    h_cmd_valid = 1'b1;
    h_cmd_mode  = mode;
    #2;
    chk("cmd_ready", h_cmd_ready, 1);
    @(negedge clk);
    h_cmd_valid = 1'b0;
    h_cmd_mode  = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int bound);
    int k = 0;
    while (done_cnt == prev && k < bound) begin
      @(negedge clk); #2; k++;
    end
    chk("done_seen", done_cnt, prev + 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic int count_bad(input logic [7:0] base, input int n, input int which);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = base + 8'(i);
      if (which == 0) begin
        if (i >= rx_q.size() || rx_q[i] !== e) bad++;
      end else begin
        if (i >= rsp_got.size() || rsp_got[i] !== e) bad++;
      end
    end
    return bad;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    logic [1:0] cnt_before;

    tbl[0] = '{1'b0, 8'h00, 16, 8'h00, 8'h50, 2'd1};
    tbl[1] = '{1'b1, 8'h20, 20, 8'h20, 8'h60, 2'd2};
    tbl[2] = '{1'b0, 8'h34, 12, 8'h30, 8'h70, 2'd3};
    tbl[3] = '{1'b1, 8'hA0, 16, 8'hA0, 8'h80, 2'd0};
    tbl[4] = '{1'b1, 8'hF0, 16, 8'hF0, 8'h90, 2'd1};

    rst_n = 1'b0; h_chal_valid = 1'b0; h_chal_data = 8'h00;
    h_cmd_valid = 1'b0; h_cmd_mode = 1'b0; h_abort = 1'b0;
    idle_cycles(2);
    chk("reset_flags", {h_chal_ready, h_cmd_ready, h_rsp_valid, o_done, o_err, o_puf_start,
                        o_puf_op_mode, o_puf_rx_valid, o_puf_tx_ready}, 9'b110000000);
    chk("reset_code", o_err_code, 0);
    chk("reset_cnt", o_frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Table of complete frames: ordering, leftovers carried over, latency, counter wrap
    for (int f = 0; f < 5; f++) begin
      push_words(tbl[f].push_base, tbl[f].n_push);
      rx_q.delete(); rsp_got.delete();
      start_cnt = 0;
      tx_base = tbl[f].tx_base;
      prev = done_cnt;
      send_cmd(tbl[f].mode);
      wait_done(prev, 200);
      idle_cycles(5);
      chk($sformatf("f%0d_cnt", f), done_frame_cnt, tbl[f].exp_cnt);
      chk($sformatf("f%0d_latency", f), done_lat, FRAM_SIZE + RSP_LEN + 2);
      chk($sformatf("f%0d_starts", f), start_cnt, 1);
      chk($sformatf("f%0d_mode", f), start_mode, tbl[f].mode);
      chk($sformatf("f%0d_code", f), o_err_code, 0);
      chk($sformatf("f%0d_rx_n", f), rx_q.size(), FRAM_SIZE);
      chk($sformatf("f%0d_rx_bad", f), count_bad(tbl[f].exp_rx_base, FRAM_SIZE, 0), 0);
      chk($sformatf("f%0d_rsp_n", f), rsp_got.size(), RSP_LEN);
      chk($sformatf("f%0d_rsp_bad", f), count_bad(tbl[f].tx_base, RSP_LEN, 1), 0);
    end

    // Command before data, one word every 3 cycles
    rx_q.delete(); rx_valid_cycles = 0;
    prev = done_cnt;
    send_cmd(1'b0);
    for (int i = 0; i < FRAM_SIZE; i++) begin
      @(negedge clk);
      h_chal_valid = 1'b1;
      h_chal_data  = 8'h60 + 8'(i);
      @(negedge clk);
      h_chal_valid = 1'b0;
      @(negedge clk);
    end
    wait_done(prev, 200);
    idle_cycles(3);
    chk("stall_rx_valid_cycles", rx_valid_cycles, FRAM_SIZE);
    chk("stall_rx_bad", count_bad(8'h60, FRAM_SIZE, 0), 0);
    chk("stall_cnt", done_frame_cnt, 2);

    // Response back-pressure: host not popping, RSP_DEPTH=2
    drain_en = 1'b0;
    push_words(8'h40, FRAM_SIZE);
    rsp_got.delete(); tx_cnt = 0; tx_base = 8'hB0;
    prev = done_cnt;
    send_cmd(1'b0);
    begin
      int k = 0;
      while (tx_cnt < 2 && k < 100) begin
        @(negedge clk); #2; k++;
      end
    end
    idle_cycles(5);
    chk("bp_tx_cnt", tx_cnt, 2);
    chk("bp_tx_ready", o_puf_tx_ready, 0);
    chk("bp_rsp_valid", h_rsp_valid, 1);
    chk("bp_rsp_head", h_rsp_data, 8'hB0);
    drain_en = 1'b1;
    wait_done(prev, 100);
    idle_cycles(5);
    chk("bp_rsp_bad", count_bad(8'hB0, RSP_LEN, 1), 0);
    chk("bp_cnt", done_frame_cnt, 3);

    // Abort after 5 rx words
    push_words(8'h10, FRAM_SIZE);
    rx_q.delete(); rx_limit = 5;
    prev = err_cnt; cnt_before = o_frame_cnt;
    send_cmd(1'b0);
    begin
      int k = 0;
      while (rx_q.size() < 5 && k < 100) begin
        @(negedge clk); #2; k++;
      end
    end
    idle_cycles(2);
    h_abort = 1'b1;
    @(negedge clk);
    h_abort = 1'b0;
    #2;
    chk("abort_idle", h_cmd_ready, 1);
    chk("abort_err", o_err, 1);
    chk("abort_code", o_err_code, 2);
    chk("abort_cnt", o_frame_cnt, cnt_before);
    chk("abort_rx_n", rx_q.size(), 5);
    rx_limit = 1000;
    // A flushed challenge FIFO means the next frame stalls with no rx_valid at all
    rx_q.delete(); rx_valid_cycles = 0;
    prev = done_cnt;
    send_cmd(1'b1);
    #2;
    chk("cmd_clears_code", o_err_code, 0);
    idle_cycles(6);
    chk("abort_flushed", rx_valid_cycles, 0);
    push_words(8'hC0, FRAM_SIZE);
    wait_done(prev, 200);
    idle_cycles(5);
    chk("post_abort_rx_bad", count_bad(8'hC0, FRAM_SIZE, 0), 0);
    chk("post_abort_cnt", done_frame_cnt, 0);

    // Timeout: core never presents tx_valid
    core_tx_en = 1'b0;
    push_words(8'h70, FRAM_SIZE);
    prev = err_cnt;
    send_cmd(1'b0);
    begin
      int k = 0;
      while (err_cnt == prev && k < 2000) begin
        @(negedge clk); #2; k++;
      end
    end
    chk("to_err_seen", err_cnt, prev + 1);
    chk("to_idle_cycles", err_to, TIMEOUT_CYC);
    chk("to_code", o_err_code, 1);
    chk("to_idle", h_cmd_ready, 1);
    chk("to_cnt", o_frame_cnt, 0);
    core_tx_en = 1'b1;

    // Reset in the middle of SEND
    push_words(8'h90, FRAM_SIZE);
    rx_q.delete(); rx_limit = 3;
    send_cmd(1'b1);
    begin
      int k = 0;
      while (rx_q.size() < 3 && k < 100) begin
        @(negedge clk); #2; k++;
      end
    end
    chk("mid_send_op_mode", o_puf_op_mode, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_flags", {h_chal_ready, h_cmd_ready, h_rsp_valid, o_done, o_err, o_puf_start,
                      o_puf_op_mode, o_puf_rx_valid, o_puf_tx_ready}, 9'b110000000);
    chk("rst_code", o_err_code, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_limit = 1000;
    idle_cycles(3);
    chk("rst_rx_valid", o_puf_rx_valid, 0);
    chk("rst_cmd_ready", h_cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
